ddr_ring_dma: RTL and testbench

//  Parametrised DDR2 DMA engine between an input FIFO (pipe-in side), the MIG p0 port and an output FIFO (pipe-out side).

---
 rtl/ddr_ring_dma.sv | 104 ++++++++++
 tb/tb_ddr_ring_dma.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_ring_dma.sv
// ddr_ring_dma: burst DMA between input FIFO, MIG p0 port and output FIFO over a circular DDR region
module ddr_ring_dma #(
    parameter int DATA_W     = 32,
    parameter int BL         = 32,
    parameter int RING_WORDS = 4096,
    parameter int OB_DEPTH   = 1023,
    parameter int HEADROOM   = 20,
    parameter int CNT_W      = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          writes_en,
    input  logic                          reads_en,
    input  logic                          calib_done,
    input  logic [29:0]                   base_addr,
    output logic                          ib_re,
    input  logic [DATA_W-1:0]             ib_data,
    input  logic [CNT_W-1:0]              ib_count,
    output logic                          ob_we,
    output logic [DATA_W-1:0]             ob_data,
    input  logic [CNT_W-1:0]              ob_count,
    output logic                          p0_cmd_en,
    output logic [2:0]                    p0_cmd_instr,
    output logic [5:0]                    p0_cmd_bl,
    output logic [29:0]                   p0_cmd_byte_addr,
    input  logic                          p0_cmd_full,
    output logic                          p0_wr_en,
    output logic [DATA_W-1:0]             p0_wr_data,
    output logic [DATA_W/8-1:0]           p0_wr_mask,
    input  logic                          p0_wr_full,
    output logic                          p0_rd_en,
    input  logic [DATA_W-1:0]             p0_rd_data,
    input  logic                          p0_rd_empty,
    output logic [$clog2(RING_WORDS):0]   fill_words,
    output logic                          busy
);
    localparam int PW = $clog2(RING_WORDS);
    localparam int FW = PW + 1;
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, RD_CMD, RD_DATA} state_t;
    state_t state, nxt;
    logic [PW-1:0] wptr, rptr;
    logic [29:0] base_q;
    logic [6:0] re_cnt, dn_cnt;
    logic last_wr, wr_ok, rd_ok, wr_done, rd_done;
    always_comb begin
        wr_ok = writes_en && int'(ib_count) >= BL && int'(fill_words) + BL <= RING_WORDS && !p0_wr_full;
        rd_ok = reads_en && int'(fill_words) >= BL && int'(ob_count) <= OB_DEPTH - HEADROOM - BL;
        ib_re = state == WR_DATA && int'(re_cnt) < BL;
        p0_rd_en = state == RD_DATA && !p0_rd_empty;
        ob_we = p0_rd_en;
        ob_data = p0_rd_en ? p0_rd_data : '0;
        p0_wr_data = p0_wr_en ? ib_data : '0;
        p0_wr_mask = '0;
        p0_cmd_en = (state == WR_CMD || state == RD_CMD) && !p0_cmd_full;
        p0_cmd_instr = p0_cmd_en && state == RD_CMD ? 3'b001 : 3'b000;
        p0_cmd_bl = p0_cmd_en ? 6'(BL - 1) : '0;
        p0_cmd_byte_addr = p0_cmd_en ? base_q + (30'(state == RD_CMD ? rptr : wptr) << 2) : '0;
        wr_done = p0_wr_en && dn_cnt == 7'(BL - 1);
        rd_done = p0_rd_en && dn_cnt == 7'(BL - 1);
        busy = state != IDLE;
    end
    // Ties go to the op opposite the last one completed, so neither side starves
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !calib_done ? IDLE : (wr_ok && (!rd_ok || !last_wr)) ? WR_DATA : rd_ok ? RD_CMD : IDLE;
            WR_DATA: nxt = wr_done ? WR_CMD : WR_DATA;
            WR_CMD:  nxt = p0_cmd_full ? WR_CMD : IDLE;
            RD_CMD:  nxt = p0_cmd_full ? RD_CMD : RD_DATA;
            RD_DATA: nxt = rd_done ? IDLE : RD_DATA;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            fill_words <= '0;
            base_q <= '0;
            re_cnt <= '0;
            dn_cnt <= '0;
            last_wr <= 1'b0;
            p0_wr_en <= 1'b0;
        end else begin
            p0_wr_en <= ib_re;
            re_cnt <= state == WR_DATA ? re_cnt + 7'(ib_re) : '0;
            dn_cnt <= (state == WR_DATA || state == RD_DATA) ? dn_cnt + 7'(p0_wr_en | p0_rd_en) : '0;
            if (state == IDLE) base_q <= base_addr;
            if (state == WR_CMD && !p0_cmd_full) begin
                wptr <= wptr == PW'(RING_WORDS - BL) ? '0 : wptr + PW'(BL);
                fill_words <= fill_words + FW'(BL);
                last_wr <= 1'b1;
            end
            if (rd_done) begin
                rptr <= rptr == PW'(RING_WORDS - BL) ? '0 : rptr + PW'(BL);
                fill_words <= fill_words - FW'(BL);
                last_wr <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ddr_ring_dma.sv
// tb_ddr_ring_dma: scoreboard bench with behavioural FIFO and MIG models around a 128-word ring
module tb_ddr_ring_dma;
    localparam int RW = 128;
    logic clk, reset, writes_en, reads_en, calib_done;
    logic [29:0] base_addr;
    logic ib_re, ob_we, p0_cmd_en, p0_cmd_full, p0_wr_en, p0_wr_full, p0_rd_en, p0_rd_empty, busy;
    logic [31:0] ib_data, ob_data, p0_wr_data, p0_rd_data;
    logic [9:0] ib_count, ob_count;
    logic [2:0] p0_cmd_instr;
    logic [5:0] p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic [3:0] p0_wr_mask;
    logic [7:0] fill_words;
    logic [31:0] exp_q[$], got_q[$], wbuf[$], rdq[$];
    logic [38:0] cmdq[$];
    logic [31:0] mem [0:4095];
    logic [31:0] src;
    int wr_pulses, ib_re_cnt, errors, checks;

    ddr_ring_dma #(.DATA_W(32), .BL(32), .RING_WORDS(RW), .OB_DEPTH(1023), .HEADROOM(20), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .writes_en(writes_en), .reads_en(reads_en), .calib_done(calib_done),
        .base_addr(base_addr), .ib_re(ib_re), .ib_data(ib_data), .ib_count(ib_count), .ob_we(ob_we),
        .ob_data(ob_data), .ob_count(ob_count), .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_bl(p0_cmd_bl), .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
        .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask), .p0_wr_full(p0_wr_full),
        .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty),
        .fill_words(fill_words), .busy(busy));

    initial clk = 0;
    always #5 clk = ~clk;

    // Input FIFO, MIG and output FIFO models; expected words enter the scoreboard as they are supplied
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete(); got_q.delete(); wbuf.delete(); rdq.delete(); cmdq.delete();
            ib_data <= '0;
            p0_rd_empty <= 1'b1;
            p0_rd_data <= '0;
        end else begin
            if (ib_re) begin
                ib_data <= src;
                exp_q.push_back(src);
                src = src + 32'h1111_0001;
                ib_re_cnt++;
            end
            if (p0_wr_en) begin
                wbuf.push_back(p0_wr_data);
                wr_pulses++;
            end
            if (ob_we) got_q.push_back(ob_data);
            if (p0_rd_en && rdq.size() > 0) void'(rdq.pop_front());
            if (p0_cmd_en) begin
                cmdq.push_back({p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr});
                for (int i = 0; i <= int'(p0_cmd_bl); i++)
                    if (p0_cmd_instr == 3'b000) mem[(int'(p0_cmd_byte_addr[13:2]) + i) % 4096] = wbuf.size() > 0 ? wbuf.pop_front() : 32'hdead_beef;
                    else rdq.push_back(mem[(int'(p0_cmd_byte_addr[13:2]) + i) % 4096]);
            end
            p0_rd_empty <= rdq.size() == 0;
            p0_rd_data <= rdq.size() > 0 ? rdq[0] : '0;
        end
    end

    task automatic pulse(input bit w, input bit r);
        @(negedge clk);
        writes_en = w;
        reads_en = r;
        @(negedge clk);
        writes_en = 0;
        reads_en = 0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if ({ib_re, ob_we, p0_cmd_en, p0_wr_en, p0_rd_en, busy} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", {ib_re, ob_we, p0_cmd_en, p0_wr_en, p0_rd_en, busy}); end
        checks++; if (fill_words !== 8'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_words); end
        checks++; if ({p0_cmd_byte_addr, p0_cmd_bl, p0_cmd_instr, p0_wr_mask, p0_wr_data, ob_data} !== '0) begin errors++; $display("FAIL reset_buses: got %0h expected 0", {p0_cmd_byte_addr, p0_cmd_bl, p0_cmd_instr}); end
        reset = 0;
        writes_en = 1;
        ib_count = 10'd32;
        repeat (5) @(negedge clk);
        checks++; if ({busy, ib_re} !== 2'b00) begin errors++; $display("FAIL no_calib_hold: got %b expected 00", {busy, ib_re}); end
        writes_en = 0;
        calib_done = 1;
    endtask

    task automatic test_write_burst;
        int w0;
        bit to;
        w0 = wr_pulses;
        @(negedge clk);
        writes_en = 1;
        @(negedge clk);
        writes_en = 0;
        checks++; if ({busy, ib_re, p0_wr_en} !== 3'b110) begin errors++; $display("FAIL first_latency: got %b expected 110", {busy, ib_re, p0_wr_en}); end
        @(negedge clk);
        checks++; if (p0_wr_en !== 1'b1) begin errors++; $display("FAIL first_wr_en: got %b expected 1", p0_wr_en); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL write_timeout: got busy expected idle"); end
        checks++; if (wr_pulses - w0 !== 32) begin errors++; $display("FAIL wr_pulses: got %0d expected 32", wr_pulses - w0); end
        checks++; if (cmdq.size() !== 1) begin errors++; $display("FAIL write_cmd_count: got %0d expected 1", cmdq.size()); end
        else begin
            checks++; if (cmdq[0] !== {3'b000, 6'd31, 30'h100}) begin errors++; $display("FAIL write_cmd: got %0h expected %0h", cmdq[0], {3'b000, 6'd31, 30'h100}); end
        end
        checks++; if (fill_words !== 8'd32) begin errors++; $display("FAIL write_fill: got %0d expected 32", fill_words); end
        cmdq.delete();
    endtask

    task automatic test_read_burst;
        bit to;
        pulse(0, 1);
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL read_timeout: got busy expected idle"); end
        checks++; if (cmdq.size() !== 1 || cmdq[0] !== {3'b001, 6'd31, 30'h100}) begin errors++; $display("FAIL read_cmd: got %0h expected %0h", cmdq.size() > 0 ? cmdq[0] : 39'h0, {3'b001, 6'd31, 30'h100}); end
        checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL read_count: got %0d expected 32", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [31:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL read_data: got %0h expected %0h", g, e); end
        end
        checks++; if (fill_words !== 8'd0) begin errors++; $display("FAIL read_fill: got %0d expected 0", fill_words); end
        cmdq.delete();
    endtask

    task automatic test_wrap;
        int wp, rp;
        bit to;
        logic [38:0] c;
        wp = 32; rp = 32;
        for (int k = 0; k < 5; k++) begin
            pulse(1, 0);
            wait_idle(to);
            c = cmdq.size() > 0 ? cmdq.pop_front() : '0;
            checks++; if (to || c !== {3'b000, 6'd31, 30'(32'h100 + 4 * wp)}) begin errors++; $display("FAIL wrap_write%0d: got %0h expected %0h", k, c, {3'b000, 6'd31, 30'(32'h100 + 4 * wp)}); end
            wp = (wp + 32) % RW;
            pulse(0, 1);
            wait_idle(to);
            c = cmdq.size() > 0 ? cmdq.pop_front() : '0;
            checks++; if (to || c !== {3'b001, 6'd31, 30'(32'h100 + 4 * rp)}) begin errors++; $display("FAIL wrap_read%0d: got %0h expected %0h", k, c, {3'b001, 6'd31, 30'(32'h100 + 4 * rp)}); end
            rp = (rp + 32) % RW;
            checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 32", k, got_q.size()); end
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                logic [31:0] g, e;
                g = got_q.pop_front(); e = exp_q.pop_front();
                checks++; if (g !== e) begin errors++; $display("FAIL wrap_data%0d: got %0h expected %0h", k, g, e); end
            end
        end
        cmdq.delete();
    endtask

    task automatic drain(input string name);
        bit to;
        int n;
        n = 0;
        @(negedge clk);
        reads_en = 1;
        while (fill_words != 0 && n < 2000) begin @(negedge clk); n++; end
        reads_en = 0;
        wait_idle(to);
        checks++; if (to || fill_words !== 8'd0) begin errors++; $display("FAIL %s_drain: got fill %0d expected 0", name, fill_words); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [31:0] g, e;
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL %s_data: got %0h expected %0h", name, g, e); end
        end
        cmdq.delete();
    endtask

    task automatic test_full;
        int n, r0;
        bit to;
        ib_count = 10'd1000;
        @(negedge clk);
        writes_en = 1;
        n = 0;
        while (cmdq.size() < 4 && n < 1000) begin @(negedge clk); n++; end
        checks++; if (cmdq.size() !== 4) begin errors++; $display("FAIL full_fill_cmds: got %0d expected 4", cmdq.size()); end
        r0 = ib_re_cnt;
        repeat (50) @(negedge clk);
        checks++; if (ib_re_cnt !== r0) begin errors++; $display("FAIL full_no_ib_re: got %0d expected %0d", ib_re_cnt, r0); end
        checks++; if ({busy, fill_words} !== {1'b0, 8'd128}) begin errors++; $display("FAIL full_hold: got busy %b fill %0d expected 0 128", busy, fill_words); end
        reads_en = 1;
        @(negedge clk);
        reads_en = 0;
        n = 0;
        while (cmdq.size() < 6 && n < 1000) begin @(negedge clk); n++; end
        writes_en = 0;
        wait_idle(to);
        checks++; if (cmdq.size() !== 6 || cmdq[4][38:36] !== 3'b001 || cmdq[5][38:36] !== 3'b000) begin errors++; $display("FAIL full_resume: got %0d cmds expected read then write", cmdq.size()); end
        checks++; if (fill_words !== 8'd128) begin errors++; $display("FAIL full_refill: got %0d expected 128", fill_words); end
        drain("full");
    endtask

    task automatic test_back_to_back;
        int n, n0, en_seen;
        bit to;
        pulse(1, 0);
        wait_idle(to);
        pulse(1, 0);
        wait_idle(to);
        cmdq.delete();
        @(negedge clk);
        writes_en = 1;
        reads_en = 1;
        n = 0;
        while (cmdq.size() < 4 && n < 1000) begin @(negedge clk); n++; end
        checks++; if (cmdq.size() < 4) begin errors++; $display("FAIL alt_count: got %0d expected 4", cmdq.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (cmdq[i][38:36] !== ((i % 2 == 0) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL alt_order%0d: got %0d expected %0d", i, cmdq[i][38:36], (i % 2 == 0) ? 1 : 0); end
        end
        n = 0;
        while (!ib_re && n < 500) begin @(negedge clk); n++; end
        p0_cmd_full = 1;
        n0 = cmdq.size();
        en_seen = 0;
        repeat (50) begin @(negedge clk); if (p0_cmd_en) en_seen++; end
        checks++; if (en_seen !== 0 || cmdq.size() !== n0) begin errors++; $display("FAIL stall_cmd_en: got %0d pulses expected 0", en_seen); end
        checks++; if ({busy, ib_re, p0_wr_en} !== 3'b100) begin errors++; $display("FAIL stall_state: got %b expected 100", {busy, ib_re, p0_wr_en}); end
        p0_cmd_full = 0;
        #1;
        checks++; if ({p0_cmd_en, p0_cmd_instr} !== 4'b1000) begin errors++; $display("FAIL stall_release: got %b expected 1000", {p0_cmd_en, p0_cmd_instr}); end
        @(negedge clk);
        writes_en = 0;
        reads_en = 0;
        wait_idle(to);
        checks++; if (cmdq.size() !== n0 + 1) begin errors++; $display("FAIL stall_one_cmd: got %0d expected %0d", cmdq.size(), n0 + 1); end
        drain("b2b");
    endtask

    task automatic test_reset_mid;
        int w0, n;
        bit to;
        ib_count = 10'd32;
        w0 = wr_pulses;
        pulse(1, 0);
        n = 0;
        while (wr_pulses - w0 < 10 && n < 100) begin @(negedge clk); n++; end
        reset = 1;
        #1;
        checks++; if ({ib_re, p0_wr_en, p0_cmd_en, busy, fill_words} !== '0) begin errors++; $display("FAIL mid_reset_out: got %0h expected 0", {ib_re, p0_wr_en, p0_cmd_en, busy, fill_words}); end
        repeat (2) @(negedge clk);
        reset = 0;
        pulse(1, 0);
        wait_idle(to);
        checks++; if (to || cmdq.size() !== 1 || cmdq[0] !== {3'b000, 6'd31, 30'h100}) begin errors++; $display("FAIL mid_restart_addr: got %0h expected %0h", cmdq.size() > 0 ? cmdq[0] : 39'h0, {3'b000, 6'd31, 30'h100}); end
        checks++; if (fill_words !== 8'd32) begin errors++; $display("FAIL mid_restart_fill: got %0d expected 32", fill_words); end
        drain("mid");
    endtask

    initial begin
        reset = 1; writes_en = 0; reads_en = 0; calib_done = 0; base_addr = 30'h100;
        ib_count = 0; ob_count = 0; p0_cmd_full = 0; p0_wr_full = 0;
        src = 32'h0; wr_pulses = 0; ib_re_cnt = 0; errors = 0; checks = 0;
        test_reset;
        test_write_burst;
        test_read_burst;
        test_wrap;
        test_full;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
